motor_pwm_driver: RTL and testbench

Per-wheel PWM motor driver that consumes the 1-bit left/right motor enable commands produced by the line-follower steering FSM. It turns each command into a glitch-free PWM waveform whose duty cycle ramps up or down in fixed steps, so the wheels never see instantaneous full-speed steps. The block sits between the steering FSM and the H-bridge pins. It reports per-wheel duty and an at-speed flag for debug and LEDs.

---
 rtl/motor_pwm_driver.sv | 137 +++++++++++++
 tb/tb_motor_pwm_driver.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/motor_pwm_driver.sv
// Two-channel ramped PWM motor driver fed by the steering FSM's 1-bit wheel enables.
// Optional macro MOTOR_BRAKE_EN: both commands low at a period end forces both channels to IDLE.
module motor_pwm_driver #(
  parameter int PWM_BITS     = 8,
  parameter int MAX_DUTY     = 200,
  parameter int STEP         = 32,
  parameter int RAMP_PERIODS = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_left,
  input  logic                cmd_right,
  output logic                pwm_left,
  output logic                pwm_right,
  output logic [PWM_BITS-1:0] duty_left,
  output logic [PWM_BITS-1:0] duty_right,
  output logic                at_speed_left,
  output logic                at_speed_right,
  output logic                period_start
);

  localparam int RC_W = (RAMP_PERIODS > 1) ? $clog2(RAMP_PERIODS) : 1;
  localparam logic [PWM_BITS-1:0] CNT_LAST = '1;
  localparam logic [RC_W-1:0]     RC_LAST  = RC_W'(RAMP_PERIODS - 1);
  localparam logic [PWM_BITS:0]   MAX_W    = (PWM_BITS + 1)'(MAX_DUTY);
  localparam logic [PWM_BITS:0]   STEP_W   = (PWM_BITS + 1)'(STEP);

  typedef enum logic [1:0] {IDLE, RAMP_UP, RUN, RAMP_DOWN} state_t;

  logic [PWM_BITS-1:0] cnt_reg;
  logic [RC_W-1:0]     rc_reg;
  logic                period_start_reg;
  logic                end_c;
  logic                tick;
  logic                brake;
  logic [1:0]          cmd_vec;

  logic [1:0][PWM_BITS-1:0] duty_vec;
  logic [1:0]               pwm_vec;
  logic [1:0]               at_vec;

  assign end_c   = (cnt_reg == CNT_LAST);
  assign tick    = end_c && (rc_reg == RC_LAST);
  assign cmd_vec = {cmd_right, cmd_left};

`ifdef MOTOR_BRAKE_EN
  // Brake is checked at every period end, not only at ramp ticks.
  assign brake = end_c && !cmd_left && !cmd_right;
`else
  assign brake = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_reg          <= '0;
      rc_reg           <= '0;
      period_start_reg <= 1'b0;
    end else begin
      cnt_reg          <= cnt_reg + 1'b1;
      period_start_reg <= end_c;
      if (end_c) begin
        rc_reg <= (rc_reg == RC_LAST) ? '0 : rc_reg + 1'b1;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_chan
      state_t              state_reg, state_next;
      logic [PWM_BITS-1:0] duty_reg, duty_next;
      logic                pwm_reg;
      logic                at_speed_reg;
      logic [PWM_BITS:0]   sum_w;

      // One extra bit so the increment cannot wrap before the clamp.
      assign sum_w = {1'b0, duty_reg} + STEP_W;

      always_comb begin
        state_next = state_reg;
        duty_next  = duty_reg;
        if (brake) begin
          state_next = IDLE;
          duty_next  = '0;
        end else if (tick) begin
          if (cmd_vec[gi]) begin
            if ({1'b0, duty_reg} < MAX_W) begin
              if (sum_w >= MAX_W) begin
                duty_next  = MAX_W[PWM_BITS-1:0];
                state_next = RUN;
              end else begin
                duty_next  = sum_w[PWM_BITS-1:0];
                state_next = RAMP_UP;
              end
            end else begin
              state_next = RUN;
            end
          end else begin
            if ({1'b0, duty_reg} > STEP_W) begin
              duty_next  = duty_reg - STEP_W[PWM_BITS-1:0];
              state_next = RAMP_DOWN;
            end else begin
              duty_next  = '0;
              state_next = IDLE;
            end
          end
        end
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          state_reg    <= IDLE;
          duty_reg     <= '0;
          pwm_reg      <= 1'b0;
          at_speed_reg <= 1'b0;
        end else begin
          state_reg    <= state_next;
          duty_reg     <= duty_next;
          at_speed_reg <= (state_next == RUN);
          pwm_reg      <= (cnt_reg < duty_reg);
        end
      end

      assign duty_vec[gi] = duty_reg;
      assign pwm_vec[gi]  = pwm_reg;
      assign at_vec[gi]   = at_speed_reg;
    end
  endgenerate

  assign pwm_left       = pwm_vec[0];
  assign pwm_right      = pwm_vec[1];
  assign duty_left      = duty_vec[0];
  assign duty_right     = duty_vec[1];
  assign at_speed_left  = at_vec[0];
  assign at_speed_right = at_vec[1];
  assign period_start   = period_start_reg;

endmodule

// File: tb/tb_motor_pwm_driver.sv
// Bench for motor_pwm_driver: vector table, corner-case sequences and a random run
// checked every cycle against a cycle-count based reference model.
module tb_motor_pwm_driver;

  localparam int PERIOD = 256;
  localparam int MAXD   = 200;
  localparam int STP    = 32;
  localparam int RP     = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_left = 1'b0;
  logic       cmd_right = 1'b0;
  logic       pwm_left, pwm_right, at_speed_left, at_speed_right, period_start;
  logic [7:0] duty_left, duty_right;

  motor_pwm_driver #(.PWM_BITS(8), .MAX_DUTY(MAXD), .STEP(STP), .RAMP_PERIODS(RP)) dut (
    .clk(clk), .reset(reset), .cmd_left(cmd_left), .cmd_right(cmd_right),
    .pwm_left(pwm_left), .pwm_right(pwm_right),
    .duty_left(duty_left), .duty_right(duty_right),
    .at_speed_left(at_speed_left), .at_speed_right(at_speed_right),
    .period_start(period_start)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  // reference model state (values the DUT should show after the latest edge)
  int m_cnt, m_rc, m_ps;
  int m_duty[2];
  int m_pwm[2];
  bit m_tick;

  typedef struct {
    bit cl; bit cr; int dl; int dr; bit al; bit ar;
  } vec_t;
  vec_t vq[$];

  function automatic vec_t mk(bit cl, bit cr, int dl, int dr, bit al, bit ar);
    vec_t v;
    v.cl = cl; v.cr = cr; v.dl = dl; v.dr = dr; v.al = al; v.ar = ar;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic timeout(input string name);
    n_total++;
    $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
  endtask

  task automatic model_reset();
    m_cnt = 0; m_rc = 0; m_ps = 0; m_tick = 0;
    for (int i = 0; i < 2; i++) begin m_duty[i] = 0; m_pwm[i] = 0; end
  endtask

  task automatic check_outputs();
    chk("duty_left", int'(duty_left), m_duty[0]);
    chk("duty_right", int'(duty_right), m_duty[1]);
    chk("pwm_left", int'(pwm_left), m_pwm[0]);
    chk("pwm_right", int'(pwm_right), m_pwm[1]);
    chk("at_speed_left", int'(at_speed_left), int'(m_duty[0] == MAXD));
    chk("at_speed_right", int'(at_speed_right), int'(m_duty[1] == MAXD));
    chk("period_start", int'(period_start), m_ps);
  endtask

  // One clock edge: advance the model from the spec rules, then compare.
  task automatic cycle();
    bit e;
    bit c[2];
    int nd[2];
    @(posedge clk);
    c[0] = cmd_left;
    c[1] = cmd_right;
    e = (m_cnt == PERIOD - 1);
    m_tick = e && (m_rc == RP - 1);
    m_ps = int'(e);
    for (int i = 0; i < 2; i++) begin
      m_pwm[i] = int'(m_cnt < m_duty[i]);
      nd[i] = m_duty[i];
      if (m_tick) begin
        if (c[i]) nd[i] = (m_duty[i] + STP > MAXD) ? MAXD : m_duty[i] + STP;
        else      nd[i] = (m_duty[i] > STP) ? m_duty[i] - STP : 0;
      end
    end
`ifdef MOTOR_BRAKE_EN
    if (e && !c[0] && !c[1]) begin nd[0] = 0; nd[1] = 0; end
`endif
    m_duty[0] = nd[0];
    m_duty[1] = nd[1];
    m_cnt = (m_cnt + 1) % PERIOD;
    if (e) m_rc = (m_rc + 1) % RP;
    #1;
    check_outputs();
  endtask

  task automatic run_to_tick(output int n);
    n = 0;
    do begin cycle(); n++; end while (!m_tick && n < 600);
    if (!m_tick) timeout("run_to_tick");
  endtask

  task automatic run_to_end();
    int n = 0;
    do begin cycle(); n++; end while (m_ps == 0 && n < 300);
    if (m_ps == 0) timeout("run_to_end");
  endtask

  // Asserted between edges: outputs must clear without waiting for a clock.
  task automatic apply_reset();
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    model_reset();
    chk("async_reset_duty_l", int'(duty_left), 0);
    chk("async_reset_pwm_r", int'(pwm_right), 0);
    check_outputs();
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1 check_outputs();
    end
    @(posedge clk);
    #3 reset = 1'b0;
  endtask

  task automatic first_step_after_reset(input string name);
    int n = 0;
    do begin cycle(); n++; end while (duty_left == 0 && n < 600);
    if (duty_left == 0) timeout(name);
    chk({name, "_edges"}, n, 512);
    chk({name, "_duty"}, int'(duty_left), STP);
  endtask

  initial begin
    int n;
    int hi_l, hi_r;
    model_reset();
    apply_reset();

    // ramp up, ramp down on the left, reversal mid-ramp
    vq.push_back(mk(1,1, 32, 32,0,0)); vq.push_back(mk(1,1, 64, 64,0,0));
    vq.push_back(mk(1,1, 96, 96,0,0)); vq.push_back(mk(1,1,128,128,0,0));
    vq.push_back(mk(1,1,160,160,0,0)); vq.push_back(mk(1,1,192,192,0,0));
    vq.push_back(mk(1,1,200,200,1,1));
    vq.push_back(mk(0,1,168,200,0,1)); vq.push_back(mk(0,1,136,200,0,1));
    vq.push_back(mk(0,1,104,200,0,1)); vq.push_back(mk(0,1, 72,200,0,1));
    vq.push_back(mk(0,1, 40,200,0,1)); vq.push_back(mk(0,1,  8,200,0,1));
    vq.push_back(mk(0,1,  0,200,0,1));
    vq.push_back(mk(1,1, 32,200,0,1)); vq.push_back(mk(1,1, 64,200,0,1));
    vq.push_back(mk(1,1, 96,200,0,1)); vq.push_back(mk(0,1, 64,200,0,1));
    vq.push_back(mk(0,1, 32,200,0,1)); vq.push_back(mk(1,1, 64,200,0,1));

    foreach (vq[k]) begin
      cmd_left = vq[k].cl;
      cmd_right = vq[k].cr;
      run_to_tick(n);
      if (k == 0) chk("first_tick_edges", n, 512);
      chk("vec_duty_left", int'(duty_left), vq[k].dl);
      chk("vec_duty_right", int'(duty_right), vq[k].dr);
      chk("vec_at_speed_left", int'(at_speed_left), int'(vq[k].al));
      chk("vec_at_speed_right", int'(at_speed_right), int'(vq[k].ar));
      $display("vec %0d cmd=%b%b duty_l=%0d duty_r=%0d at_l=%b at_r=%b",
               k, cmd_left, cmd_right, duty_left, duty_right, at_speed_left, at_speed_right);
    end

    // right channel at full duty: 200 high cycles per period
    hi_r = 0;
    for (int i = 0; i < PERIOD; i++) begin cycle(); hi_r += int'(pwm_right); end
    chk("pwm_right_high_count", hi_r, MAXD);
    $display("seq pwm_right high %0d of %0d", hi_r, PERIOD);

    // glitch on cmd_right between ticks must be ignored
    cmd_left = 1'b1; cmd_right = 1'b1;
    run_to_tick(n);
    for (int i = 0; i < 10; i++) cycle();
    cmd_right = 1'b0;
    for (int i = 0; i < 90; i++) cycle();
    cmd_right = 1'b1;
    run_to_tick(n);
    chk("toggle_duty_right", int'(duty_right), MAXD);
    chk("toggle_duty_left", int'(duty_left), 128);
    $display("seq toggle duty_l=%0d duty_r=%0d", duty_left, duty_right);

    // bring left to full speed, then drop both commands at cnt=10 of a non-tick period
    for (int i = 0; i < 3; i++) run_to_tick(n);
    chk("pre_stop_duty_left", int'(duty_left), MAXD);
    for (int i = 0; i < 10; i++) cycle();
    chk("stop_rc_not_last", m_rc, 0);
    cmd_left = 1'b0; cmd_right = 1'b0;
    run_to_end();
`ifdef MOTOR_BRAKE_EN
    chk("brake_duty_left", int'(duty_left), 0);
    chk("brake_duty_right", int'(duty_right), 0);
    chk("brake_at_speed_left", int'(at_speed_left), 0);
    hi_l = 0; hi_r = 0;
    for (int i = 0; i < PERIOD; i++) begin
      cycle(); hi_l += int'(pwm_left); hi_r += int'(pwm_right);
    end
    chk("brake_pwm_left_high", hi_l, 0);
    chk("brake_pwm_right_high", hi_r, 0);
`else
    chk("nobrake_duty_left", int'(duty_left), MAXD);
    chk("nobrake_duty_right", int'(duty_right), MAXD);
    run_to_tick(n);
    chk("nobrake_ramp_left", int'(duty_left), MAXD - STP);
    chk("nobrake_ramp_right", int'(duty_right), MAXD - STP);
`endif
    $display("seq stop duty_l=%0d duty_r=%0d", duty_left, duty_right);

    // reset at cnt=100 while ramping up
    apply_reset();
    cmd_left = 1'b1; cmd_right = 1'b1;
    run_to_tick(n);
    run_to_tick(n);
    for (int i = 0; i < 100; i++) cycle();
    chk("pre_reset_cnt", m_cnt, 100);
    chk("pre_reset_duty_left", int'(duty_left), 64);
    apply_reset();
    first_step_after_reset("restart");
    $display("seq reset restart duty_l=%0d", duty_left);

    // random commands against the reference model
    for (int i = 0; i < 30000; i++) begin
      if ($urandom_range(0, 299) == 0) cmd_left = ~cmd_left;
      if ($urandom_range(0, 299) == 0) cmd_right = ~cmd_right;
      cycle();
      if (m_tick)
        $display("rnd tick cyc=%0d cmd=%b%b duty_l=%0d duty_r=%0d",
                 i, cmd_left, cmd_right, duty_left, duty_right);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
